// File: rtl/ac97_csr_issuer.sv
// ac97_csr_issuer
// Buffers per-cycle CSR write requests from the AC97 DMA controller in a small
// FIFO and replays them as paced single-cycle write strobes on the AC97 core's
// CSR slave port. Queue status, a sticky overflow flag and a completed-write
// counter are reported alongside.

module ac97_csr_issuer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     crreq,
    input  logic [13:0]              csr_addr,
    input  logic [31:0]              csr_data,
    input  logic                     clr_ovf,
    output logic [13:0]              csr_a,
    output logic                     csr_we,
    output logic [31:0]              csr_do,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [15:0]              wr_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [45:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;
    logic          r_full;

    // Bus-side state and registered outputs
    state_t        r_state;
    logic [3:0]    r_gapCnt;
    logic [13:0]   r_csrA;
    logic [31:0]   r_csrDo;
    logic          r_csrWe;
    logic          r_busy;
    logic          r_ovf;
    logic [15:0]   r_wrCount;

    // Handshake between the FIFO and the FSM
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_isFull;
    logic [LW-1:0] w_levelNext;
    logic [45:0]   w_head;

    assign w_isFull = (r_level == LW'(DEPTH));
    assign w_push   = crreq && (!w_isFull || w_pop);
    assign w_drop   = crreq && w_isFull && !w_pop;
    assign w_head   = r_mem[r_rdPtr];

    // The FSM pops the head whenever it is about to enter WRITE and data is waiting
    always_comb begin
        w_pop = 1'b0;
        if (r_level != '0) begin
            case (r_state)
                ST_IDLE:  w_pop = 1'b1;
                ST_WRITE: w_pop = (GAP == 0);
                ST_GAP:   w_pop = (r_gapCnt == 4'd1);
                default:  w_pop = 1'b0;
            endcase
        end
    end

    // Occupancy after this edge: push and pop together leave it unchanged
    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - 1'b1;
        end
    end

    // Entry storage; accepted requests land at the write pointer
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wrPtr] <= {csr_addr, csr_data};
        end
    end

    // Pointer, level and full tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_level <= w_levelNext;
            r_full  <= (w_levelNext == LW'(DEPTH));
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Bus FSM: issues one strobe per entry, then waits GAP idle cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_gapCnt  <= 4'd0;
            r_csrA    <= 14'd0;
            r_csrDo   <= 32'd0;
            r_csrWe   <= 1'b0;
            r_busy    <= 1'b0;
            r_wrCount <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_csrA  <= w_head[45:32];
                        r_csrDo <= w_head[31:0];
                        r_csrWe <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_WRITE;
                    end else begin
                        r_csrWe <= 1'b0;
                        r_busy  <= (w_levelNext != '0);
                    end
                end
                ST_WRITE: begin
                    r_wrCount <= r_wrCount + 16'd1;
                    if (GAP > 0) begin
                        r_gapCnt <= 4'(GAP);
                        r_csrWe  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_GAP;
                    end else if (w_pop) begin
                        r_csrA  <= w_head[45:32];
                        r_csrDo <= w_head[31:0];
                        r_csrWe <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_csrWe <= 1'b0;
                        r_busy  <= (w_levelNext != '0);
                        r_state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    r_gapCnt <= r_gapCnt - 4'd1;
                    if (r_gapCnt == 4'd1) begin
                        if (w_pop) begin
                            r_csrA  <= w_head[45:32];
                            r_csrDo <= w_head[31:0];
                            r_csrWe <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            r_csrWe <= 1'b0;
                            r_busy  <= (w_levelNext != '0);
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_csrWe <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_csrWe <= 1'b0;
                    r_busy  <= (w_levelNext != '0);
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign csr_a    = r_csrA;
    assign csr_we   = r_csrWe;
    assign csr_do   = r_csrDo;
    assign busy     = r_busy;
    assign full     = r_full;
    assign level    = r_level;
    assign ovf      = r_ovf;
    assign wr_count = r_wrCount;

endmodule

// File: tb/tb_ac97_csr_issuer.sv
// tb_ac97_csr_issuer
// Directed bench for ac97_csr_issuer. Three instances share one set of inputs:
// G1 (DEPTH 4, GAP 1), G0 (DEPTH 4, GAP 0) and D2 (DEPTH 2, GAP 3). Each
// scenario watches the instance it targets; cycle 0 is the first cycle in
// which a request is driven after reset.

module tb_ac97_csr_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        crreq;
    logic [13:0] csrAddr;
    logic [31:0] csrData;
    logic        clrOvf;

    logic [13:0] aG1, aG0, aD2;
    logic        weG1, weG0, weD2;
    logic [31:0] doG1, doG0, doD2;
    logic        busyG1, busyG0, busyD2;
    logic        fullG1, fullG0, fullD2;
    logic [2:0]  levelG1, levelG0;
    logic [1:0]  levelD2;
    logic        ovfG1, ovfG0, ovfD2;
    logic [15:0] cntG1, cntG0, cntD2;

    int vectorsApplied = 0;
    int miscompares    = 0;

    ac97_csr_issuer #(.DEPTH(4), .GAP(1)) dutG1 (
        .clk(clk), .rst(rst), .crreq(crreq), .csr_addr(csrAddr), .csr_data(csrData),
        .clr_ovf(clrOvf), .csr_a(aG1), .csr_we(weG1), .csr_do(doG1), .busy(busyG1),
        .full(fullG1), .level(levelG1), .ovf(ovfG1), .wr_count(cntG1)
    );

    ac97_csr_issuer #(.DEPTH(4), .GAP(0)) dutG0 (
        .clk(clk), .rst(rst), .crreq(crreq), .csr_addr(csrAddr), .csr_data(csrData),
        .clr_ovf(clrOvf), .csr_a(aG0), .csr_we(weG0), .csr_do(doG0), .busy(busyG0),
        .full(fullG0), .level(levelG0), .ovf(ovfG0), .wr_count(cntG0)
    );

    ac97_csr_issuer #(.DEPTH(2), .GAP(3)) dutD2 (
        .clk(clk), .rst(rst), .crreq(crreq), .csr_addr(csrAddr), .csr_data(csrData),
        .clr_ovf(clrOvf), .csr_a(aD2), .csr_we(weD2), .csr_do(doD2), .busy(busyD2),
        .full(fullD2), .level(levelD2), .ovf(ovfD2), .wr_count(cntD2)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Drive one cycle's worth of request-side inputs
    task automatic applyStimulus(input logic req, input logic [13:0] addr,
                                 input logic [31:0] data, input logic clr);
        crreq   = req;
        csrAddr = addr;
        csrData = data;
        clrOvf  = clr;
    endtask

    // Count one comparison and report it if the DUT disagrees
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges, then release it one cycle before cycle 0
    task automatic resetDuts();
        rst = 1'b0;
        applyStimulus(1'b0, 14'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scenario sequencing
    initial begin
        logic [13:0] burstAddr [3];
        logic [31:0] burstData [3];
        int idxG1;
        int idxG0;
        int idxD2;
        int strobes;
        int orderErr;
        bit expWe;

        burstAddr[0] = 14'h00; burstData[0] = 32'h1;
        burstAddr[1] = 14'h14; burstData[1] = 32'h20;
        burstAddr[2] = 14'h10; burstData[2] = 32'h1;

        // Reset state on all instances
        rst = 1'b0;
        applyStimulus(1'b1, 14'h3FFF, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWeG1",    weG1,    0);
        checkOutput("rstAG1",     aG1,     0);
        checkOutput("rstDoG1",    doG1,    0);
        checkOutput("rstBusyG1",  busyG1,  0);
        checkOutput("rstLevelG1", levelG1, 0);
        checkOutput("rstFullD2",  fullD2,  0);
        checkOutput("rstOvfD2",   ovfD2,   0);
        checkOutput("rstCntG0",   cntG0,   0);

        // Single request, GAP 1
        resetDuts();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c == 0, 14'h14, 32'h0000_1000, 1'b0);
            @(negedge clk);
            checkOutput("singleWe", weG1, (c == 2));
            if (c == 1) begin
                checkOutput("singleLevel", levelG1, 1);
                checkOutput("singleBusy",  busyG1,  1);
            end
            if (c == 2) begin
                checkOutput("singleAddr", aG1,  14'h14);
                checkOutput("singleData", doG1, 32'h0000_1000);
            end
            if (c == 3) checkOutput("singleCount", cntG1, 1);
            if (c == 4) checkOutput("singleIdle",  busyG1, 0);
            @(posedge clk);
            #1;
        end

        // Three-request burst: paced on G1, back-to-back on G0
        resetDuts();
        idxG1 = 0;
        idxG0 = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 3) applyStimulus(1'b1, burstAddr[c], burstData[c], 1'b0);
            else       applyStimulus(1'b0, 14'd0, 32'd0, 1'b0);
            @(negedge clk);
            expWe = (c == 2 || c == 4 || c == 6);
            checkOutput("burstWeG1", weG1, expWe);
            if (weG1 && idxG1 < 3) begin
                checkOutput("burstAddrG1", aG1,  burstAddr[idxG1]);
                checkOutput("burstDataG1", doG1, burstData[idxG1]);
                idxG1++;
            end
            expWe = (c >= 2 && c <= 4);
            checkOutput("b2bWeG0", weG0, expWe);
            if (weG0 && idxG0 < 3) begin
                checkOutput("b2bAddrG0", aG0,  burstAddr[idxG0]);
                checkOutput("b2bDataG0", doG0, burstData[idxG0]);
                idxG0++;
            end
            checkOutput("burstOvfG1", ovfG1, 0);
            if (c == 5) begin
                checkOutput("burstHoldAddr", aG1,  14'h14);
                checkOutput("burstHoldData", doG1, 32'h20);
            end
            if (c == 9) begin
                checkOutput("burstCountG1", cntG1,   3);
                checkOutput("b2bCountG0",   cntG0,   3);
                checkOutput("burstLevelG1", levelG1, 0);
                checkOutput("burstIdleG1",  busyG1,  0);
            end
            @(posedge clk);
            #1;
        end

        // Overflow on the two-entry, GAP 3 instance
        resetDuts();
        idxD2 = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(c <= 4, 14'(14'h100 + c), 32'(c), c == 12);
            @(negedge clk);
            expWe = (c == 2 || c == 6 || c == 10);
            checkOutput("ovfWe", weD2, expWe);
            if (weD2) begin
                checkOutput("ovfAddr", aD2,  14'(14'h100 + idxD2));
                checkOutput("ovfData", doD2, 32'(idxD2));
                idxD2++;
            end
            checkOutput("ovfFlag", ovfD2, (c >= 4 && c <= 12));
            if (c == 3) begin
                checkOutput("ovfFull",  fullD2,  1);
                checkOutput("ovfLevel", levelD2, 2);
            end
            if (c == 15) begin
                checkOutput("ovfCount",   cntD2,  3);
                checkOutput("ovfStrobes", idxD2,  3);
                checkOutput("ovfIdle",    busyD2, 0);
                checkOutput("ovfNotFull", fullD2, 0);
            end
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a GAP 1 burst, then a fresh request
        resetDuts();
        for (int c = 0; c < 13; c++) begin
            rst = !(c == 3);
            applyStimulus(c <= 3 || c == 9, 14'(14'h40 + c), 32'(32'hA0 + c), 1'b0);
            @(negedge clk);
            if (c == 2) begin
                checkOutput("midWePre",   weG1, 1);
                checkOutput("midDataPre", doG1, 32'hA0);
            end
            if (c >= 4) checkOutput("midWe", weG1, (c == 11));
            if (c >= 4 && c <= 8) begin
                checkOutput("midAddr",  aG1,     0);
                checkOutput("midData",  doG1,    0);
                checkOutput("midCount", cntG1,   0);
                checkOutput("midBusy",  busyG1,  0);
                checkOutput("midLevel", levelG1, 0);
            end
            if (c == 11) begin
                checkOutput("midNewAddr", aG1,  14'h49);
                checkOutput("midNewData", doG1, 32'hA9);
            end
            if (c == 12) checkOutput("midNewCount", cntG1, 1);
            @(posedge clk);
            #1;
        end

        // 65536 back-to-back writes on G0 to wrap the write counter
        resetDuts();
        strobes  = 0;
        orderErr = 0;
        for (int c = 0; c < 65542; c++) begin
            applyStimulus(c < 65536, 14'(c), 32'(c), 1'b0);
            @(negedge clk);
            if (weG0) begin
                if (doG0 !== 32'(strobes) || aG0 !== 14'(strobes)) orderErr++;
                strobes++;
            end
            if (c == 65537) checkOutput("wrapCountMax", cntG0, 16'hFFFF);
            @(posedge clk);
            #1;
        end
        checkOutput("wrapStrobes", strobes,  65536);
        checkOutput("wrapOrder",   orderErr, 0);
        checkOutput("wrapCount",   cntG0,    0);
        checkOutput("wrapOvf",     ovfG0,    0);
        checkOutput("wrapIdle",    busyG0,   0);

        // Bus keeps working after the counter wrapped
        for (int c = 0; c < 5; c++) begin
            applyStimulus(c == 0, 14'h2AA, 32'h5555_AAAA, 1'b0);
            @(negedge clk);
            checkOutput("postWrapWe", weG0, (c == 2));
            if (c == 2) begin
                checkOutput("postWrapAddr", aG0,  14'h2AA);
                checkOutput("postWrapData", doG0, 32'h5555_AAAA);
            end
            if (c == 4) checkOutput("postWrapCount", cntG0, 1);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
